axi_lite_regfile: RTL and testbench

- AXI4-Lite slave register file; the downstream consumer of the team's AXI-Lite master bus model and of any CPU/bridge master.
- Exposes NUM_RW read/write control registers as a flat output bus and NUM_RO read-only status words sampled from inputs.
- Provides per-register write pulses so user logic can trigger on register writes.
- Supports one outstanding write and one outstanding read; the two channels are fully independent.

---
 rtl/axi_lite_pkg.sv | 18 +
 rtl/axi_lite_regfile_wr.sv | 104 ++++++++++
 rtl/axi_lite_regfile.sv | 150 +++++++++++++++
 tb/tb_axi_lite_regfile.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and channel FSM state encodings.
// Used by axi_lite_regfile and axi_lite_regfile_wr.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

endpackage

// File: rtl/axi_lite_regfile_wr.sv
// AXI4-Lite write channel: independent AW/W latching, commit strobe and B response.
// Byte strobes are honoured only when AXI_LITE_REGFILE_WSTRB_EN is defined.
module axi_lite_regfile_wr #(
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_RW     = 8
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    output logic                  wr_commit,
    output logic [ADDR_WIDTH-1:0] wr_idx,
    output logic                  wr_in_rw,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [STRB_WIDTH-1:0] wr_strb
);
    import axi_lite_pkg::*;

    w_state_t              state;
    w_state_t              state_nxt;
    logic                  up;
    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  aw_hs;
    logic                  w_hs;

    assign aw_hs     = s_axi_awvalid && s_axi_awready;
    assign w_hs      = s_axi_wvalid && s_axi_wready;
    assign wr_commit = (state == W_IDLE) && aw_held && w_held;
    assign wr_idx    = addr_q >> $clog2(STRB_WIDTH);
    assign wr_in_rw  = wr_idx < ADDR_WIDTH'(NUM_RW);

    // up keeps the readies low until the first edge after reset release
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state <= W_IDLE;
            up    <= 1'b0;
        end else begin
            state <= state_nxt;
            up    <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            W_IDLE: if (wr_commit) state_nxt = W_RESP;
            W_RESP: if (s_axi_bready) state_nxt = W_IDLE;
            default: state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        s_axi_awready = up && (state == W_IDLE) && !aw_held;
        s_axi_wready  = up && (state == W_IDLE) && !w_held;
        s_axi_bvalid  = (state == W_RESP);
        s_axi_bresp   = (s_axi_bvalid && !wr_in_rw) ? RESP_SLVERR : RESP_OKAY;
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            addr_q  <= '0;
            wr_data <= '0;
            wr_strb <= '0;
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                addr_q  <= s_axi_awaddr;
            end
            if (w_hs) begin
                w_held  <= 1'b1;
                wr_data <= s_axi_wdata;
`ifdef AXI_LITE_REGFILE_WSTRB_EN
                wr_strb <= s_axi_wstrb;
`else
                wr_strb <= '1;
`endif
            end
            if (wr_commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

`ifndef AXI_LITE_REGFILE_WSTRB_EN
    logic unused_wstrb;
    assign unused_wstrb = ^s_axi_wstrb;
`endif

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite register file: NUM_RW control registers, NUM_RO status words, write pulses.
// Define AXI_LITE_REGFILE_WSTRB_EN to enable per-byte write strobes.
module axi_lite_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_RW     = 8,
    parameter int NUM_RO     = 4
) (
    input  logic                         s_axi_aclk,
    input  logic                         s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]        s_axi_awaddr,
    input  logic                         s_axi_awvalid,
    output logic                         s_axi_awready,
    input  logic [DATA_WIDTH-1:0]        s_axi_wdata,
    input  logic [STRB_WIDTH-1:0]        s_axi_wstrb,
    input  logic                         s_axi_wvalid,
    output logic                         s_axi_wready,
    output logic [1:0]                   s_axi_bresp,
    output logic                         s_axi_bvalid,
    input  logic                         s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    output logic [DATA_WIDTH-1:0]        s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    output logic [NUM_RW*DATA_WIDTH-1:0] ctrl_regs,
    output logic [NUM_RW-1:0]            wr_pulse,
    input  logic [((NUM_RO > 0) ? NUM_RO : 1)*DATA_WIDTH-1:0] status_in
);
    import axi_lite_pkg::*;

    logic                  wr_commit;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic                  wr_in_rw;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_WIDTH-1:0] wr_strb;
    logic [DATA_WIDTH-1:0] regs [NUM_RW];

    axi_lite_regfile_wr #(
        .DATA_WIDTH (DATA_WIDTH),
        .STRB_WIDTH (STRB_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_RW     (NUM_RW)
    ) u_wr (
        .s_axi_aclk    (s_axi_aclk),
        .s_axi_aresetn (s_axi_aresetn),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .wr_commit     (wr_commit),
        .wr_idx        (wr_idx),
        .wr_in_rw      (wr_in_rw),
        .wr_data       (wr_data),
        .wr_strb       (wr_strb)
    );

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            for (int i = 0; i < NUM_RW; i++) regs[i] <= '0;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            for (int i = 0; i < NUM_RW; i++) begin
                if (wr_commit && wr_in_rw && wr_idx == ADDR_WIDTH'(i)) begin
                    wr_pulse[i] <= 1'b1;
                    for (int k = 0; k < STRB_WIDTH; k++)
                        if (wr_strb[k]) regs[i][k*8 +: 8] <= wr_data[k*8 +: 8];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_RW; g++) begin : g_ctrl
        assign ctrl_regs[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end

    r_state_t              r_state;
    r_state_t              r_nxt;
    logic                  rd_up;
    logic                  ar_hs;
    logic [ADDR_WIDTH-1:0] ar_idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rd_hit;

    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign ar_idx = s_axi_araddr >> $clog2(STRB_WIDTH);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state <= R_IDLE;
            rd_up   <= 1'b0;
        end else begin
            r_state <= r_nxt;
            rd_up   <= 1'b1;
        end
    end

    always_comb begin
        r_nxt = r_state;
        unique case (r_state)
            R_IDLE: if (ar_hs) r_nxt = R_DATA;
            R_DATA: if (s_axi_rready) r_nxt = R_IDLE;
            default: r_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        s_axi_arready = rd_up && (r_state == R_IDLE);
        s_axi_rvalid  = (r_state == R_DATA);
    end

    // read sees register contents before any same-edge write commits
    always_comb begin
        rd_word = '0;
        rd_hit  = 1'b0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (ar_idx == ADDR_WIDTH'(i)) begin
                rd_word = regs[i];
                rd_hit  = 1'b1;
            end
        end
        for (int j = 0; j < NUM_RO; j++) begin
            if (ar_idx == ADDR_WIDTH'(NUM_RW + j)) begin
                rd_word = status_in[j*DATA_WIDTH +: DATA_WIDTH];
                rd_hit  = 1'b1;
            end
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s_axi_rdata <= '0;
            s_axi_rresp <= RESP_OKAY;
        end else if (ar_hs) begin
            s_axi_rdata <= rd_word;
            s_axi_rresp <= rd_hit ? RESP_OKAY : RESP_SLVERR;
        end
    end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Randomized self-checking bench for axi_lite_regfile against a word-level model.
// Honours AXI_LITE_REGFILE_WSTRB_EN the same way the design does.
module tb_axi_lite_regfile;

    localparam int LIMIT = 50;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  awaddr = '0;
    logic         awvalid = 1'b0;
    logic         awready;
    logic [31:0]  wdata = '0;
    logic [3:0]   wstrb = '0;
    logic         wvalid = 1'b0;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready = 1'b0;
    logic [31:0]  araddr = '0;
    logic         arvalid = 1'b0;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready = 1'b0;
    logic [255:0] ctrl_regs;
    logic [7:0]   wr_pulse;
    logic [127:0] status_in = '0;

    int checks = 0;
    int errors = 0;
    logic [31:0] ref_regs [8];

    always #5 clk = ~clk;

    axi_lite_regfile dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .ctrl_regs     (ctrl_regs),
        .wr_pulse      (wr_pulse),
        .status_in     (status_in)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) begin
`ifdef AXI_LITE_REGFILE_WSTRB_EN
            if (strb[k]) r[k*8 +: 8] = nw[k*8 +: 8];
`else
            r[k*8 +: 8] = nw[k*8 +: 8];
`endif
        end
        return r;
    endfunction

    // model: applies a write to the reference array, returns expected resp and pulse
    task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, output logic [1:0] resp,
                               output logic [7:0] pulse);
        int idx;
        idx = int'(addr >> 2);
        if (addr < 32'h20) begin
            ref_regs[idx] = merge(ref_regs[idx], data, strb);
            resp = 2'b00;
            pulse = 8'(1 << idx);
        end else begin
            resp = 2'b10;
            pulse = 8'h00;
        end
    endtask

    task automatic model_read(input logic [31:0] addr, output logic [31:0] data,
                              output logic [1:0] resp);
        int idx;
        idx = int'(addr >> 2);
        if (addr < 32'h20) begin
            data = ref_regs[idx];
            resp = 2'b00;
        end else if (addr < 32'h30) begin
            data = status_in[(idx-8)*32 +: 32];
            resp = 2'b00;
        end else begin
            data = 32'h0;
            resp = 2'b10;
        end
    endtask

    function automatic logic [255:0] model_ctrl();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = ref_regs[i];
        return v;
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp,
                             output logic [7:0] pulse);
        int n;
        logic aw_go, w_go;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; n = 0;
        while ((awvalid || wvalid) && n < LIMIT) begin
            aw_go = awvalid && awready;
            w_go = wvalid && wready;
            tick();
            if (aw_go) awvalid = 1'b0;
            if (w_go) wvalid = 1'b0;
            n++;
        end
        while (!bvalid && n < LIMIT) begin
            tick();
            n++;
        end
        checks++;
        if (!bvalid) begin
            errors++;
            $display("FAIL write_timeout addr=%h bvalid=%b required 1", addr, bvalid);
        end
        awvalid = 1'b0; wvalid = 1'b0;
        resp = bresp; pulse = wr_pulse;
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int n;
        logic go;
        araddr = addr; arvalid = 1'b1; n = 0;
        while (arvalid && n < LIMIT) begin
            go = arready;
            tick();
            if (go) arvalid = 1'b0;
            n++;
        end
        checks++;
        if (!rvalid) begin
            errors++;
            $display("FAIL read_latency addr=%h rvalid=%b required 1", addr, rvalid);
        end
        arvalid = 1'b0;
        data = rdata; resp = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) ref_regs[i] = '0;
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata, wr_pulse} !== '0
            || ctrl_regs !== '0) begin
            errors++;
            $display("FAIL reset_outputs aw=%b w=%b ar=%b rdata=%h ctrl=%h required all 0",
                     awready, wready, arready, rdata, ctrl_regs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({awready, wready, arready} !== 3'b000) begin
            errors++;
            $display("FAIL ready_before_edge got %b required 000", {awready, wready, arready});
        end
        tick();
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++;
            $display("FAIL ready_after_edge got %b required 111", {awready, wready, arready});
        end
        bready = 1'b1; rready = 1'b1;
        repeat (2) tick();
        bready = 1'b0; rready = 1'b0;
        checks++;
        if ({bvalid, rvalid, awready, arready} !== 4'b0011) begin
            errors++;
            $display("FAIL idle_ready_ignored got %b required 0011",
                     {bvalid, rvalid, awready, arready});
        end
    endtask

    task automatic test_basic();
        logic [1:0] resp, eresp;
        logic [7:0] pulse, epulse;
        logic [31:0] d;
        model_write(32'h04, 32'hA5A5_0001, 4'hF, eresp, epulse);
        axi_write(32'h04, 32'hA5A5_0001, 4'hF, resp, pulse);
        checks++;
        if (resp !== 2'b00 || pulse !== 8'b0000_0010 || ctrl_regs[63:32] !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL basic_write resp=%b pulse=%b word1=%h required 00 00000010 a5a50001",
                     resp, pulse, ctrl_regs[63:32]);
        end
        checks++;
        if (wr_pulse !== 8'h00) begin
            errors++;
            $display("FAIL pulse_one_cycle got %b required 0", wr_pulse);
        end
        axi_read(32'h04, d, resp);
        checks++;
        if (d !== 32'hA5A5_0001 || resp !== 2'b00) begin
            errors++;
            $display("FAIL basic_read got %h/%b required a5a50001/00", d, resp);
        end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] eresp;
        logic [7:0] epulse;
        logic held_ok;
        model_write(32'h00, 32'h1234_5678, 4'hF, eresp, epulse);
        wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        repeat (2) tick();
        checks++;
        if (wready !== 1'b0 || bvalid !== 1'b0) begin
            errors++;
            $display("FAIL w_held wready=%b bvalid=%b required 0 0", wready, bvalid);
        end
        awaddr = 32'h00; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        checks++;
        if (bvalid !== 1'b0) begin
            errors++;
            $display("FAIL commit_early bvalid=%b required 0", bvalid);
        end
        tick();
        checks++;
        if (bvalid !== 1'b1 || wr_pulse !== 8'h01 || bresp !== 2'b00) begin
            errors++;
            $display("FAIL commit_edge bvalid=%b pulse=%b bresp=%b required 1 00000001 00",
                     bvalid, wr_pulse, bresp);
        end
        held_ok = 1'b1;
        repeat (5) begin
            tick();
            if (bvalid !== 1'b1 || bresp !== 2'b00 || wr_pulse !== 8'h00) held_ok = 1'b0;
        end
        checks++;
        if (!held_ok) begin
            errors++;
            $display("FAIL bvalid_hold got %b required 1", held_ok);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        checks++;
        if (bvalid !== 1'b0 || ctrl_regs !== model_ctrl() || awready !== 1'b1) begin
            errors++;
            $display("FAIL b_done bvalid=%b awready=%b word0=%h required 0 1 %h",
                     bvalid, awready, ctrl_regs[31:0], ref_regs[0]);
        end
    endtask

    task automatic test_status();
        logic [1:0] resp, eresp;
        logic [7:0] pulse, epulse;
        logic [31:0] d, ed;
        status_in = {$urandom, $urandom, $urandom, 32'hDEAD_BEEF};
        axi_read(32'h20, d, resp);
        checks++;
        if (d !== 32'hDEAD_BEEF || resp !== 2'b00) begin
            errors++;
            $display("FAIL ro_read got %h/%b required deadbeef/00", d, resp);
        end
        model_write(32'h20, 32'h5555_AAAA, 4'hF, eresp, epulse);
        axi_write(32'h20, 32'h5555_AAAA, 4'hF, resp, pulse);
        checks++;
        if (resp !== 2'b10 || pulse !== 8'h00 || ctrl_regs !== model_ctrl()) begin
            errors++;
            $display("FAIL ro_write resp=%b pulse=%b required 10 00000000", resp, pulse);
        end
        axi_read(32'h40, d, resp);
        checks++;
        if (d !== 32'h0 || resp !== 2'b10) begin
            errors++;
            $display("FAIL unmapped_read got %h/%b required 0/10", d, resp);
        end
        axi_read(32'h2C, d, resp);
        model_read(32'h2C, ed, eresp);
        checks++;
        if (d !== ed || resp !== 2'b00) begin
            errors++;
            $display("FAIL last_ro got %h/%b required %h/00", d, resp, ed);
        end
        axi_read(32'h30, d, resp);
        checks++;
        if (d !== 32'h0 || resp !== 2'b10) begin
            errors++;
            $display("FAIL first_unmapped got %h/%b required 0/10", d, resp);
        end
    endtask

    task automatic test_strobe();
        logic [1:0] resp, eresp;
        logic [7:0] pulse, epulse;
        logic [31:0] exp2;
`ifdef AXI_LITE_REGFILE_WSTRB_EN
        exp2 = 32'hFF00_FF00;
`else
        exp2 = 32'h0000_0000;
`endif
        model_write(32'h08, 32'hFFFF_FFFF, 4'hF, eresp, epulse);
        axi_write(32'h08, 32'hFFFF_FFFF, 4'hF, resp, pulse);
        model_write(32'h08, 32'h0000_0000, 4'b0101, eresp, epulse);
        axi_write(32'h08, 32'h0000_0000, 4'b0101, resp, pulse);
        checks++;
        if (ctrl_regs[95:64] !== exp2 || resp !== 2'b00 || pulse !== 8'h04) begin
            errors++;
            $display("FAIL strobe_partial reg2=%h resp=%b pulse=%b required %h 00 00000100",
                     ctrl_regs[95:64], resp, pulse, exp2);
        end
        model_write(32'h08, 32'h1357_9BDF, 4'b0000, eresp, epulse);
        axi_write(32'h08, 32'h1357_9BDF, 4'b0000, resp, pulse);
        checks++;
        if (ctrl_regs !== model_ctrl() || resp !== 2'b00 || pulse !== 8'h04) begin
            errors++;
            $display("FAIL strobe_zero reg2=%h resp=%b pulse=%b required %h 00 00000100",
                     ctrl_regs[95:64], resp, pulse, ref_regs[2]);
        end
    endtask

    task automatic test_same_edge();
        logic [1:0] resp, eresp;
        logic [7:0] pulse, epulse;
        logic [31:0] d;
        model_write(32'h0C, 32'h22, 4'hF, eresp, epulse);
        axi_write(32'h0C, 32'h22, 4'hF, resp, pulse);
        awaddr = 32'h0C; wdata = 32'h11; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h0C; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        model_write(32'h0C, 32'h11, 4'hF, eresp, epulse);
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'h22 || bvalid !== 1'b1 || wr_pulse !== 8'h08) begin
            errors++;
            $display("FAIL same_edge rvalid=%b rdata=%h bvalid=%b pulse=%b required 1 22 1 00001000",
                     rvalid, rdata, bvalid, wr_pulse);
        end
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        axi_read(32'h0C, d, resp);
        checks++;
        if (d !== 32'h11 || resp !== 2'b00) begin
            errors++;
            $display("FAIL after_same_edge got %h/%b required 11/00", d, resp);
        end
    endtask

    task automatic test_random();
        logic [1:0] resp, eresp;
        logic [7:0] pulse, epulse;
        logic [31:0] d, ed, addr, data;
        logic [3:0] strb;
        for (int n = 0; n < 60; n++) begin
            status_in = {$urandom, $urandom, $urandom, $urandom};
            addr = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
            if ($urandom_range(0, 9) == 0) addr = 32'h8000_0000 | addr;
            data = $urandom;
            strb = 4'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                model_write(addr, data, strb, eresp, epulse);
                axi_write(addr, data, strb, resp, pulse);
                checks++;
                if (resp !== eresp || pulse !== epulse || ctrl_regs !== model_ctrl()) begin
                    errors++;
                    $display("FAIL rand_write addr=%h resp=%b pulse=%b required %b %b",
                             addr, resp, pulse, eresp, epulse);
                end
            end else begin
                model_read(addr, ed, eresp);
                axi_read(addr, d, resp);
                checks++;
                if (d !== ed || resp !== eresp) begin
                    errors++;
                    $display("FAIL rand_read addr=%h got %h/%b required %h/%b",
                             addr, d, resp, ed, eresp);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [1:0] resp, eresp;
        logic [7:0] pulse, epulse;
        logic [31:0] data;
        int n;
        awaddr = 32'h14; wdata = 32'hCAFE_0000; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h04; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        n = 0;
        while (!(bvalid && rvalid) && n < LIMIT) begin
            tick();
            n++;
        end
        checks++;
        if (!(bvalid && rvalid)) begin
            errors++;
            $display("FAIL midflight_setup bvalid=%b rvalid=%b required 1 1", bvalid, rvalid);
        end
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) ref_regs[i] = '0;
        checks++;
        if ({awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata, wr_pulse} !== '0
            || ctrl_regs !== '0) begin
            errors++;
            $display("FAIL async_reset bvalid=%b rvalid=%b rdata=%h ctrl=%h required all 0",
                     bvalid, rvalid, rdata, ctrl_regs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
            errors++;
            $display("FAIL post_reset_ready got %b required 11100",
                     {awready, wready, arready, bvalid, rvalid});
        end
        data = $urandom;
        model_write(32'h10, data, 4'hF, eresp, epulse);
        axi_write(32'h10, data, 4'hF, resp, pulse);
        checks++;
        if (resp !== 2'b00 || pulse !== 8'h10 || ctrl_regs !== model_ctrl()) begin
            errors++;
            $display("FAIL post_reset_write resp=%b pulse=%b word4=%h required 00 00010000 %h",
                     resp, pulse, ctrl_regs[159:128], data);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_w_before_aw();
        test_status();
        test_strobe();
        test_same_edge();
        test_random();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
